// File: rtl/rom_word_fetch_pkg.sv
// Shared encodings for the multi-byte flash ROM fetch front-end.
package rom_word_fetch_pkg;

  // size field: byte count minus one
  typedef enum logic [1:0] {
    SIZE_8  = 2'd0,
    SIZE_16 = 2'd1,
    SIZE_24 = 2'd2,
    SIZE_32 = 2'd3
  } size_e;

  typedef enum logic {
    STATE_IDLE   = 1'b0,
    STATE_SETTLE = 1'b1
  } state_e;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int ADDR_W = 24;

endpackage

// File: rtl/rom_word_fetch.sv
// Fetches 1..4 bytes from the paged flash ROM and assembles them little-endian,
// holding each address until the ROM has been quiet for SETTLE cycles.
module rom_word_fetch
  import rom_word_fetch_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] address,
  input  logic [1:0]        size,
  output logic [31:0]       data_out,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_enable,
  input  logic [BYTE_W-1:0] rom_data,
  input  logic              rom_busy
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  state_e                        state;
  size_e                         last_idx;
  logic [1:0]                    idx;
  logic [CW-1:0]                 cnt;
  logic [LANES-1:0][BYTE_W-1:0]  acc;
  logic [LANES-1:0][BYTE_W-1:0]  acc_capt;

  // accumulator with the current ROM byte dropped into lane idx
  always_comb begin
    acc_capt      = acc;
    acc_capt[idx] = rom_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= STATE_IDLE;
      last_idx    <= SIZE_8;
      idx         <= '0;
      cnt         <= '0;
      acc         <= '0;
      data_out    <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      rom_address <= '0;
      rom_enable  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (start) begin
            rom_address <= address;
            last_idx    <= size_e'(size);
            idx         <= '0;
            cnt         <= '0;
            acc         <= '0;
            busy        <= 1'b1;
            rom_enable  <= 1'b1;
            state       <= STATE_SETTLE;
          end
        end
        STATE_SETTLE: begin
          // a refill restarts the stability count from zero
          if (rom_busy) begin
            cnt <= '0;
          end else if (cnt < SETTLE_C) begin
            cnt <= cnt + CW'(1);
          end else begin
            acc <= acc_capt;
            if (idx == 2'(last_idx)) begin
              data_out   <= acc_capt;
              done       <= 1'b1;
              busy       <= 1'b0;
              rom_enable <= 1'b0;
              state      <= STATE_IDLE;
            end else begin
              idx         <= idx + 2'd1;
              rom_address <= rom_address + ADDR_W'(1);
              cnt         <= '0;
            end
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_word_fetch.sv
// Directed bench for rom_word_fetch with a small registered flash ROM model.
module tb_rom_word_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] address;
  logic [1:0]  size;
  logic [31:0] data_out;
  logic        done;
  logic        busy;
  logic [23:0] rom_address;
  logic        rom_enable;
  logic [7:0]  rom_data = 8'h00;
  logic        rom_busy = 1'b0;

  int total = 0;
  int bad   = 0;

  logic        arm;
  logic        fired = 1'b0;
  int          refill_cnt = 0;
  logic [23:0] addr_log[$];
  logic        en_drop;
  logic        busy_k1;

  rom_word_fetch #(.SETTLE(2)) dut (
    .clk(clk), .reset(reset), .start(start), .address(address), .size(size),
    .data_out(data_out), .done(done), .busy(busy), .rom_address(rom_address),
    .rom_enable(rom_enable), .rom_data(rom_data), .rom_busy(rom_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h001234: return 8'h5A;
      24'h002000: return 8'h11;
      24'h002001: return 8'h22;
      24'h002002: return 8'h33;
      24'h002003: return 8'h44;
      24'h003FFF: return 8'hAA;
      24'h004000: return 8'hBB;
      24'hFFFFFE: return 8'h01;
      24'hFFFFFF: return 8'h02;
      24'h000000: return 8'h03;
      24'h000001: return 8'h04;
      default:    return a[7:0] ^ a[15:8] ^ 8'hC3;
    endcase
  endfunction

  // registered data; one 50-cycle refill when 0x004000 is first addressed
  always @(posedge clk) begin
    rom_data <= mem_byte(rom_address);
    if (!arm) fired <= 1'b0;
    if (arm && !fired && rom_enable && rom_address == 24'h004000) begin
      fired      <= 1'b1;
      refill_cnt <= 50;
      rom_busy   <= 1'b1;
    end else if (refill_cnt > 1) begin
      refill_cnt <= refill_cnt - 1;
      rom_busy   <= 1'b1;
    end else begin
      refill_cnt <= 0;
      rom_busy   <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // returns edges from accept to the edge raising done (0 on timeout)
  task automatic do_fetch(input logic [23:0] a, input logic [1:0] s, input int inj,
                          output int lat, output logic [31:0] d);
    lat = 0;
    d = 'x;
    en_drop = 1'b0;
    addr_log.delete();
    start = 1'b1; address = a; size = s;
    @(posedge clk); #1;
    start = 1'b0;
    addr_log.push_back(rom_address);
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (k == 1) busy_k1 = busy;
      if (k == inj + 1) start = 1'b0;
      if (done) begin
        lat = k;
        d = data_out;
        break;
      end
      if (!rom_enable) en_drop = 1'b1;
      if (busy && rom_address != addr_log[addr_log.size()-1]) addr_log.push_back(rom_address);
      if (k == inj) begin
        start = 1'b1; address = 24'h001234; size = 2'd0;
      end
    end
    if (lat == 0) chk("fetch_timeout", 32'd0, 32'd1);
  endtask

  int          lat;
  logic [31:0] d;

  initial begin
    reset = 1'b0; start = 1'b0; address = '0; size = '0; arm = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_ctrl", {29'd0, done, busy, rom_enable}, 32'h0);
    chk("rst_rom_addr", {8'd0, rom_address}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    do_fetch(24'h001234, 2'd0, 0, lat, d);
    chk("b1_busy", {31'd0, busy_k1}, 32'd1);
    chk("b1_lat", lat, 3);
    chk("b1_data", d, 32'h0000005A);
    chk("b1_rom_addr", {8'd0, rom_address}, 32'h001234);
    chk("b1_busy_low", {31'd0, busy}, 32'd0);

    do_fetch(24'h002000, 2'd3, 0, lat, d);
    chk("w32_lat", lat, 12);
    chk("w32_data", d, 32'h44332211);
    @(posedge clk); #1;
    chk("done_width", {31'd0, done}, 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("idle_hold", data_out, 32'h44332211);

    do_fetch(24'h001234, 2'd0, 0, lat, d);
    chk("b1_upper_zero", d, 32'h0000005A);

    arm = 1'b1;
    do_fetch(24'h003FFF, 2'd1, 0, lat, d);
    arm = 1'b0;
    chk("pg_lat", lat, 57);
    chk("pg_data", d, 32'h0000BBAA);
    chk("pg_enable", {31'd0, en_drop}, 32'd0);

    do_fetch(24'hFFFFFE, 2'd3, 0, lat, d);
    chk("wrap_lat", lat, 12);
    chk("wrap_data", d, 32'h04030201);
    chk("wrap_nlog", addr_log.size(), 4);
    chk("wrap_a0", {8'd0, (addr_log.size() > 0) ? addr_log[0] : 24'hBADBAD}, 32'hFFFFFE);
    chk("wrap_a1", {8'd0, (addr_log.size() > 1) ? addr_log[1] : 24'hBADBAD}, 32'hFFFFFF);
    chk("wrap_a2", {8'd0, (addr_log.size() > 2) ? addr_log[2] : 24'hBADBAD}, 32'h000000);
    chk("wrap_a3", {8'd0, (addr_log.size() > 3) ? addr_log[3] : 24'hBADBAD}, 32'h000001);

    do_fetch(24'h002000, 2'd1, 2, lat, d);
    chk("ign_lat", lat, 6);
    chk("ign_data", d, 32'h00002211);
    do_fetch(24'h002002, 2'd1, 0, lat, d);
    chk("b2b_lat", lat, 6);
    chk("b2b_data", d, 32'h00004433);

    start = 1'b1; address = 24'h002000; size = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mrst_ctrl", {29'd0, done, busy, rom_enable}, 32'h0);
    chk("mrst_data", data_out, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_fetch(24'h002000, 2'd3, 0, lat, d);
    chk("post_rst_lat", lat, 12);
    chk("post_rst_data", d, 32'h44332211);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
